aes_rom_arbiter: RTL and testbench

Arbitrates the single external 8-bit S-box ROM port between several S-box word requesters: encipher datapath, key memory and decipher datapath. Each requester submits a 32-bit word of four byte indices. The block sequences four ROM reads per word and returns the 32-bit substituted word with a one-cycle response pulse. It sits between the requesting sub-blocks and the top-level `rom_*` pins and is the only driver of `rom_addr`, `rom_ce_n` and `rom_oe_n`.

---
 rtl/aes_rom_pkg.sv | 14 +
 rtl/aes_rom_rr_arbiter.sv | 52 +++++
 rtl/aes_rom_arbiter.sv | 106 ++++++++++
 tb/tb_aes_rom_arbiter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/aes_rom_pkg.sv
// Shared types and constants for the S-box ROM arbiter.
package aes_rom_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_RESP = 2'd2
  } aes_rom_state_e;

  localparam int AES_ROM_BYTES_PER_WORD = 4;

  localparam int REQ_KEYMEM = 0;
  localparam int REQ_ENC    = 1;
  localparam int REQ_DEC    = 2;
endpackage

// File: rtl/aes_rom_rr_arbiter.sv
// Winner select for the S-box ROM port. Round-robin when AES_ROM_ARB_RR_EN is
// defined, otherwise a fixed-priority encoder (lowest index wins).
module aes_rom_rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int IDXW    = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic               grant_en,
  output logic               win_valid,
  output logic [IDXW-1:0]    win_idx
);

`ifdef AES_ROM_ARB_RR_EN
  logic [IDXW-1:0] ptr;
  int              idx;

  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!win_valid && req_valid[idx]) begin
        win_valid = 1'b1;
        win_idx   = IDXW'(idx);
      end
    end
  end

  // Pointer lands on the requester after the one just granted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      ptr <= '0;
    else if (grant_en && win_valid)
      ptr <= (int'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + 1'b1;
  end
`else
  logic unused_ok;
  assign unused_ok = ^{clk, reset_n, grant_en};

  always_comb begin
    win_valid = |req_valid;
    win_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (req_valid[k]) win_idx = IDXW'(k);
  end
`endif

endmodule

// File: rtl/aes_rom_arbiter.sv
// Shares the 8-bit S-box ROM between word requesters; four reads per word.
// Arbitration policy selected by AES_ROM_ARB_RR_EN (round-robin vs fixed).
module aes_rom_arbiter
  import aes_rom_pkg::*;
#(
  parameter int NUM_REQ  = 3,
  parameter int ROM_WAIT = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*32-1:0] req_word,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [31:0]           rsp_word,
  output logic                  busy,
  output logic [7:0]            rom_addr,
  input  logic [7:0]            rom_data,
  output logic                  rom_ce_n,
  output logic                  rom_oe_n
);
  localparam int IDXW = $clog2(NUM_REQ);

  aes_rom_state_e  state, state_nxt;
  logic            win_valid, grant, byte_done, last_byte;
  logic [IDXW-1:0] win_idx, sel_q;
  logic [31:0]     word_q, result_q, rsp_word_q, addr_sh;
  logic [1:0]      byte_idx;
  logic [2:0]      wait_cnt;

  aes_rom_rr_arbiter #(.NUM_REQ(NUM_REQ), .IDXW(IDXW)) u_arb (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .grant_en  (grant),
    .win_valid (win_valid),
    .win_idx   (win_idx)
  );

  assign grant     = (state == ST_IDLE) && win_valid && reset_n;
  assign byte_done = (state == ST_READ) && (wait_cnt == 3'(ROM_WAIT));
  assign last_byte = (byte_idx == 2'(AES_ROM_BYTES_PER_WORD - 1));
  assign addr_sh   = word_q << {byte_idx, 3'b000};
  assign rsp_word  = rsp_word_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (grant) state_nxt = ST_READ;
      ST_READ: if (byte_done && last_byte) state_nxt = ST_RESP;
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      word_q     <= '0;
      result_q   <= '0;
      rsp_word_q <= '0;
      sel_q      <= '0;
      byte_idx   <= '0;
      wait_cnt   <= '0;
    end else if (grant) begin
      word_q   <= req_word[32*win_idx +: 32];
      sel_q    <= win_idx;
      byte_idx <= '0;
      wait_cnt <= '0;
    end else if (state == ST_READ) begin
      if (byte_done) begin
        // Byte 0 is the MSB lane, so the result slot is (3 - byte_idx).
        result_q[{~byte_idx, 3'b000} +: 8] <= rom_data;
        if (last_byte) rsp_word_q <= {result_q[31:8], rom_data};
        byte_idx <= byte_idx + 2'd1;
        wait_cnt <= '0;
      end else begin
        wait_cnt <= wait_cnt + 3'd1;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    rom_ce_n  = 1'b1;
    rom_oe_n  = 1'b1;
    rom_addr  = 8'h00;
    busy      = (state != ST_IDLE);
    case (state)
      ST_IDLE: if (grant) req_ready[win_idx] = 1'b1;
      ST_READ: begin
        rom_ce_n = 1'b0;
        rom_oe_n = 1'b0;
        rom_addr = addr_sh[31:24];
      end
      ST_RESP: rsp_valid[sel_q] = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_aes_rom_arbiter.sv
// Directed bench for aes_rom_arbiter: per-cycle vector table plus hand sequences.
module tb_aes_rom_arbiter;
  import aes_rom_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic [2:0]  req_valid, req_ready, rsp_valid;
  logic [95:0] req_word;
  logic [31:0] rsp_word;
  logic        busy, rom_ce_n, rom_oe_n;
  logic [7:0]  rom_addr, rom_data;

  logic [2:0]  req_valid0, req_ready0, rsp_valid0;
  logic [95:0] req_word0;
  logic [31:0] rsp_word0;
  logic        busy0, rom_ce_n0, rom_oe_n0;
  logic [7:0]  rom_addr0, rom_data0;

  function automatic logic [7:0] sbox(input logic [7:0] a);
    case (a)
      8'h00:   return 8'h63;
      8'h01:   return 8'h7c;
      8'h53:   return 8'hed;
      8'hff:   return 8'h16;
      default: return 8'h00;
    endcase
  endfunction

  assign rom_data  = sbox(rom_addr);
  assign rom_data0 = sbox(rom_addr0);

  aes_rom_arbiter #(.NUM_REQ(3), .ROM_WAIT(1)) u_dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_word(req_word),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_word(rsp_word), .busy(busy),
    .rom_addr(rom_addr), .rom_data(rom_data), .rom_ce_n(rom_ce_n), .rom_oe_n(rom_oe_n)
  );

  aes_rom_arbiter #(.NUM_REQ(3), .ROM_WAIT(0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid0), .req_word(req_word0),
    .req_ready(req_ready0), .rsp_valid(rsp_valid0), .rsp_word(rsp_word0), .busy(busy0),
    .rom_addr(rom_addr0), .rom_data(rom_data0), .rom_ce_n(rom_ce_n0), .rom_oe_n(rom_oe_n0)
  );

  typedef struct {
    logic [2:0]  valid;
    logic [2:0]  ready;
    logic [2:0]  rspv;
    logic [31:0] rword;
    logic [7:0]  addr;
    logic        ce_n;
    logic        busy;
  } vec_t;

  vec_t tbl[11];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic int oh2i(input logic [2:0] v);
    for (int i = 0; i < 3; i++) if (v[i]) return i;
    return -1;
  endfunction

  initial begin
    logic [7:0]  addrs[8];
    logic [31:0] exp_w[3];
    int          order[4];
    int          n_grant, n_rsp, got, ce_low, ri;
    logic        keep0, regrant, bad, drop0;
    logic [2:0]  drop;
    logic [31:0] w;

    addrs = '{8'h00, 8'h00, 8'h01, 8'h01, 8'h53, 8'h53, 8'hff, 8'hff};
    tbl[0] = '{3'b010, 3'b010, 3'b000, 32'h0, 8'h00, 1'b1, 1'b0};
    for (int i = 1; i <= 8; i++)
      tbl[i] = '{3'b010, 3'b000, 3'b000, 32'h0, addrs[i-1], 1'b0, 1'b1};
    tbl[9]  = '{3'b010, 3'b000, 3'b010, 32'h637ced16, 8'h00, 1'b1, 1'b1};
    tbl[10] = '{3'b000, 3'b000, 3'b000, 32'h637ced16, 8'h00, 1'b1, 1'b0};

    // Reset state
    reset_n = 1'b0; req_valid = '0; req_word = '0; req_valid0 = '0; req_word0 = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_state", {19'h0, req_ready, rsp_valid, rsp_word, rom_addr, rom_ce_n, rom_oe_n, busy},
        {19'h0, 3'b000, 3'b000, 32'h0, 8'h00, 1'b1, 1'b1, 1'b0});
    reset_n = 1'b1;

    // Single request, ROM_WAIT=1, cycle-by-cycle table
    req_word[REQ_ENC*32 +: 32] = 32'h000153ff;
    for (int i = 0; i < 11; i++) begin
      req_valid = tbl[i].valid;
      #1;
      chk($sformatf("single_c%0d", i),
          {15'h0, req_ready, rsp_valid, rsp_word, rom_addr, rom_ce_n, rom_oe_n, busy},
          {15'h0, tbl[i].ready, tbl[i].rspv, tbl[i].rword, tbl[i].addr, tbl[i].ce_n, tbl[i].ce_n, tbl[i].busy});
      step();
    end

    // Three-way contention; requester 0 re-requests once through its response
    req_word = {32'hff530100, 32'h53ff0001, 32'h00000000};
    exp_w = '{32'h63636363, 32'hed16637c, 32'h16ed7c63};
    req_valid = 3'b111; keep0 = 1'b1; drop = '0; n_grant = 0; n_rsp = 0;
    for (int i = 0; i < 4; i++) order[i] = -1;
    for (int c = 0; c < 80; c++) begin
      req_valid = req_valid & ~drop;
      drop = '0;
      #1;
      if (|req_ready && n_grant < 4) begin
        order[n_grant] = oh2i(req_ready);
        n_grant++;
      end
      if (|rsp_valid) begin
        ri = oh2i(rsp_valid);
        chk($sformatf("contend_word_r%0d", ri), {32'h0, rsp_word}, {32'h0, exp_w[ri]});
        n_rsp++;
        if (ri == 0 && keep0) keep0 = 1'b0;
        else drop[ri] = 1'b1;
      end
      if (n_rsp == 4) break;
      step();
    end
    req_valid = '0;
    chk("contend_done", 64'(n_rsp), 64'd4);
`ifdef AES_ROM_ARB_RR_EN
    chk("rr_order0", 64'(order[0]), 64'd0);
    chk("rr_order1", 64'(order[1]), 64'd1);
    chk("rr_order2", 64'(order[2]), 64'd2);
    chk("rr_order3", 64'(order[3]), 64'd0);
`else
    chk("fp_order0", 64'(order[0]), 64'd0);
    chk("fp_order1", 64'(order[1]), 64'd0);
    chk("fp_order2", 64'(order[2]), 64'd1);
    chk("fp_order3", 64'(order[3]), 64'd2);
`endif
    step();

    // Withdrawal two cycles after grant
    req_word[REQ_DEC*32 +: 32] = 32'h00015300;
    req_valid = 3'b100;
    #1;
    chk("withdraw_grant", {61'h0, req_ready}, {61'h0, 3'b100});
    got = -1; w = '0; regrant = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (c == 2) req_valid = '0;
      #1;
      if (rsp_valid[REQ_DEC] && got < 0) begin got = c; w = rsp_word; end
      if (c > 9 && req_ready != 3'b000) regrant = 1'b1;
    end
    chk("withdraw_rsp_cycle", 64'(got), 64'd9);
    chk("withdraw_rsp_word", {32'h0, w}, {32'h0, 32'h637ced63});
    chk("withdraw_no_regrant", {63'h0, regrant}, 64'h0);

    // ROM_WAIT=0 instance
    req_word0[31:0] = 32'hffffffff;
    req_valid0 = 3'b001;
    #1;
    chk("w0_grant", {61'h0, req_ready0}, {61'h0, 3'b001});
    got = -1; w = '0; ce_low = 0; drop0 = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (drop0) req_valid0 = '0;
      #1;
      if (!rom_ce_n0 && !rom_oe_n0) ce_low++;
      if (rsp_valid0[0] && got < 0) begin got = c; w = rsp_word0; drop0 = 1'b1; end
    end
    chk("w0_strobe_cycles", 64'(ce_low), 64'd4);
    chk("w0_rsp_cycle", 64'(got), 64'd5);
    chk("w0_rsp_word", {32'h0, w}, {32'h0, 32'h16161616});

    // Reset during byte 2, then the held request is re-served
    req_word[REQ_ENC*32 +: 32] = 32'h000153ff;
    req_valid = 3'b010;
    #1;
    chk("rst_first_grant", {61'h0, req_ready}, {61'h0, 3'b010});
    for (int c = 1; c <= 5; c++) step();
    #1;
    chk("rst_in_byte2", {55'h0, rom_ce_n, rom_addr}, {55'h0, 1'b0, 8'h53});
    reset_n = 1'b0;
    #1;
    chk("rst_async_clear", {24'h0, rom_ce_n, rom_oe_n, busy, rsp_valid, rsp_word},
        {24'h0, 1'b1, 1'b1, 1'b0, 3'b000, 32'h0});
    bad = 1'b0;
    repeat (2) begin
      step();
      #1;
      if (rsp_valid != 3'b000 || !rom_ce_n) bad = 1'b1;
    end
    chk("rst_hold_quiet", {63'h0, bad}, 64'h0);
    reset_n = 1'b1;
    #1;
    chk("rst_regrant", {61'h0, req_ready}, {61'h0, 3'b010});
    got = -1; w = '0;
    for (int c = 1; c <= 20; c++) begin
      step();
      #1;
      if (rsp_valid[REQ_ENC] && got < 0) begin got = c; w = rsp_word; req_valid = '0; end
    end
    chk("rst_rsp_cycle", 64'(got), 64'd9);
    chk("rst_rsp_word", {32'h0, w}, {32'h0, 32'h637ced16});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
